// File: rtl/neat_evo_pkg.sv
// Shared gene layout, attribute masks and sequencer state encoding for the
// child-genome evolution datapath.
package neat_evo_pkg;

  localparam int GENE_W   = 25;
  localparam int TYPE_BIT = 24;
  localparam int ATTR_W   = 8;

  localparam logic GENE_NODE = 1'b0;
  localparam logic GENE_CONN = 1'b1;

  // Crossover threshold: 0.5 in the 1.7 fixed-point random domain.
  localparam logic [ATTR_W-1:0] HALF = 8'h40;

  typedef enum logic [1:0] {
    IDLE,
    ATTR,
    EMIT
  } state_t;

  // Legal value range of a mutated attribute, per gene type and attribute index.
  function automatic logic [ATTR_W-1:0] attr_mask(input logic gtype, input logic [1:0] k);
    logic [ATTR_W-1:0] m;
    m = 8'h00;
    if (gtype == GENE_NODE) begin
      case (k)
        2'd0:    m = 8'hFF;
        2'd1:    m = 8'h0F;
        default: m = 8'h07;
      endcase
    end else begin
      case (k)
        2'd0:    m = 8'h01;
        default: m = 8'h00;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/gene_evolve_seq_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); shifts left when en, reloads SEED on rst.
// Single-cycle update, no backpressure of its own: the owner gates en.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/gene_evolve_seq.sv
// Per-gene crossover/mutation sequencer: one parent pair in, one child gene out.
// Latency 4 cycles (1 on type mismatch); in_ready only in IDLE, EMIT holds until out_ready.
module gene_evolve_seq
  import neat_evo_pkg::*;
#(
  parameter logic [7:0] SEED0 = 8'hA5,
  parameter logic [7:0] SEED1 = 8'h3C,
  parameter logic [7:0] SEED2 = 8'h5F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [GENE_W-1:0] gene_a,
  input  logic [GENE_W-1:0] gene_b,
  input  logic              in_last,
  input  logic              bias,
  input  logic [7:0]        mutation_prob,
  input  logic              rnd_force_en,
  input  logic [23:0]       rnd_force,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GENE_W-1:0] child_gene,
  output logic              out_last,
  output logic              type_err,
  output logic [7:0]        mut_count,
  output logic              done
);

  state_t state_q, state_d;

  logic [1:0]        k_q;
  logic [GENE_W-1:0] child_q;
  logic [23:0]       gb_q;
  logic              last_q;
  logic              bias_q;
  logic              err_q;
  logic              done_q;
  logic [7:0]        cnt_q;

  logic [7:0] l0, l1, l2;
  logic [7:0] r0, r1, r2;
  logic       lfsr_en;
  logic       mismatch;

  logic [7:0] attr_a, attr_b, new_attr;
  logic       sel, mutate;

  assign lfsr_en  = (state_q == ATTR);
  assign mismatch = gene_a[TYPE_BIT] != gene_b[TYPE_BIT];

  lfsr8 #(.SEED(SEED0)) u_lfsr_xover (.clk(clk), .rst(rst), .en(lfsr_en), .q(l0));
  lfsr8 #(.SEED(SEED1)) u_lfsr_mdec  (.clk(clk), .rst(rst), .en(lfsr_en), .q(l1));
  lfsr8 #(.SEED(SEED2)) u_lfsr_mval  (.clk(clk), .rst(rst), .en(lfsr_en), .q(l2));

  assign {r2, r1, r0} = rnd_force_en ? rnd_force : {l2, l1, l0};

  // child_q is preloaded with parent A, so slice k still holds A's attribute
  // until it is overwritten in its own ATTR cycle.
  always_comb begin
    attr_a = 8'h00;
    attr_b = 8'h00;
    case (k_q)
      2'd0: begin
        attr_a = child_q[23:16];
        attr_b = gb_q[23:16];
      end
      2'd1: begin
        attr_a = child_q[15:8];
        attr_b = gb_q[15:8];
      end
      default: begin
        attr_a = child_q[7:0];
        attr_b = gb_q[7:0];
      end
    endcase
    sel      = (r0 > HALF) ? ~bias_q : bias_q;
    mutate   = !(r1 > mutation_prob);
    new_attr = mutate ? (r2 & attr_mask(child_q[TYPE_BIT], k_q))
                      : (sel ? attr_b : attr_a);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = mismatch ? EMIT : ATTR;
        end
      end
      ATTR: begin
        if (k_q == 2'd2) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= 2'd0;
      child_q <= '0;
      gb_q    <= '0;
      last_q  <= 1'b0;
      bias_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            child_q <= gene_a;
            gb_q    <= gene_b[23:0];
            last_q  <= in_last;
            bias_q  <= bias;
            err_q   <= mismatch;
            k_q     <= 2'd0;
          end
        end
        ATTR: begin
          case (k_q)
            2'd0:    child_q[23:16] <= new_attr;
            2'd1:    child_q[15:8]  <= new_attr;
            default: child_q[7:0]   <= new_attr;
          endcase
          k_q <= k_q + 2'd1;
          if (mutate && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        EMIT: begin
          if (out_ready && last_q) begin
            done_q <= 1'b1;
            cnt_q  <= 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  assign child_gene = child_q;
  assign out_last   = last_q;
  assign type_err   = err_q;
  assign mut_count  = cnt_q;
  assign done       = done_q;

endmodule

// File: tb/tb_gene_evolve_seq.sv
// Scoreboard bench for gene_evolve_seq: driver pushes model results, monitor
// pops and compares on each output handshake.
module tb_gene_evolve_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] gene_a, gene_b;
  logic        in_last, bias;
  logic [7:0]  mutation_prob;
  logic        rnd_force_en;
  logic [23:0] rnd_force;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] child_gene;
  logic        out_last, type_err, done;
  logic [7:0]  mut_count;

  gene_evolve_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .gene_a(gene_a), .gene_b(gene_b), .in_last(in_last), .bias(bias),
    .mutation_prob(mutation_prob), .rnd_force_en(rnd_force_en), .rnd_force(rnd_force),
    .out_valid(out_valid), .out_ready(out_ready), .child_gene(child_gene),
    .out_last(out_last), .type_err(type_err), .mut_count(mut_count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] child;
    logic        last;
    logic        err;
    logic [7:0]  cnt;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic stall_hold = 1'b0;

  logic [7:0] m_lfsr [3];
  int m_cnt;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    out_ready = stall_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic model_reset();
    m_lfsr[0] = 8'hA5;
    m_lfsr[1] = 8'h3C;
    m_lfsr[2] = 8'h5F;
    m_cnt = 0;
  endtask

  // Feedback bit is the parity of taps 7,5,4,3.
  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return (x << 1) | 8'(^(x & 8'hB8));
  endfunction

  task automatic push_expected(input logic [24:0] ga, input logic [24:0] gb, input logic last,
                               input logic b, input logic [7:0] mp, input logic fen,
                               input logic [23:0] frc);
    exp_t e;
    logic [7:0] res [3];
    logic [7:0] r0, r1, r2;
    logic take_b;
    e.last = last;
    if (ga[24] != gb[24]) begin
      e.child = ga;
      e.err = 1'b1;
      e.lat = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r0 = fen ? frc[7:0]   : m_lfsr[0];
        r1 = fen ? frc[15:8]  : m_lfsr[1];
        r2 = fen ? frc[23:16] : m_lfsr[2];
        take_b = (r0 > 8'd64) ? !b : b;
        res[i] = take_b ? gb[23-8*i -: 8] : ga[23-8*i -: 8];
        if (r1 <= mp) begin
          if (ga[24] == 1'b0)
            res[i] = (i == 0) ? r2 : (i == 1) ? r2 % 16 : r2 % 8;
          else
            res[i] = (i == 0) ? r2 % 2 : 8'd0;
          if (m_cnt < 255) m_cnt++;
        end
        for (int j = 0; j < 3; j++) m_lfsr[j] = lfsr_step(m_lfsr[j]);
      end
      e.child = {ga[24], res[0], res[1], res[2]};
      e.err = 1'b0;
      e.lat = 3;  // EMIT appears three edges after the accepting edge (cycle T+4)
    end
    e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
    if (last) m_cnt = 0;
  endtask

  task automatic send(input logic [24:0] ga, input logic [24:0] gb, input logic last,
                      input logic b, input logic [7:0] mp, input logic fen, input logic [23:0] frc);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("in_ready_timeout");
      return;
    end
    gene_a = ga; gene_b = gb; in_last = last; bias = b;
    mutation_prob = mp; rnd_force_en = fen; rnd_force = frc;
    in_valid = 1'b1;
    push_expected(ga, gb, last, b, mp, fen, frc);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  logic prev_valid = 1'b0;
  logic pend_done = 1'b0;
  logic pend_last = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      pend_done = 1'b0;
    end else begin
      if (pend_done) begin
        check("done_pulse", done, pend_last);
        if (pend_last) check("mut_count_clear", mut_count, 0);
        pend_done = 1'b0;
      end
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_out_valid");
        else check("latency", cyc - acc_cyc, exp_q[0].lat);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("child_gene", child_gene, e.child);
          check("out_last", out_last, e.last);
          check("type_err", type_err, e.err);
          check("mut_count", mut_count, e.cnt);
          pend_done = 1'b1;
          pend_last = e.last;
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] ga, gb;
    int n;
    rst = 1'b1; in_valid = 1'b0; gene_a = '0; gene_b = '0; in_last = 1'b0; bias = 1'b0;
    mutation_prob = 8'h00; rnd_force_en = 1'b0; rnd_force = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_child", child_gene, 0);
    check("rst_mut_count", mut_count, 0);
    check("rst_done", done, 0);
    check("rst_type_err", type_err, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b0;

    // Crossover forced, mutation off, threshold boundary on r0.
    send(25'h0112233, 25'h0AABBCC, 1'b0, 1'b0, 8'h00, 1'b1, {8'h00, 8'hFF, 8'h41});
    send(25'h0112233, 25'h0AABBCC, 1'b0, 1'b0, 8'h00, 1'b1, {8'h00, 8'hFF, 8'h40});
    send(25'h0112233, 25'h0AABBCC, 1'b0, 1'b1, 8'h00, 1'b1, {8'h00, 8'hFF, 8'h40});
    // Forced mutation, node then conn.
    send(25'h0112233, 25'h0AABBCC, 1'b0, 1'b0, 8'h20, 1'b1, {8'hDE, 8'h10, 8'h00});
    send(25'h1112233, 25'h1AABBCC, 1'b1, 1'b0, 8'h20, 1'b1, {8'hDE, 8'h10, 8'h00});
    // Type mismatch followed by a free-running gene exposes any LFSR slip.
    send(25'h0123456, 25'h1ABCDEF, 1'b0, 1'b0, 8'h80, 1'b0, 24'h0);
    send(25'h0123456, 25'h0ABCDEF, 1'b0, 1'b1, 8'h80, 1'b0, 24'h0);
    drain();

    // Stall with last.
    stall_hold = 1'b1;
    send(25'h0102030, 25'h0405060, 1'b1, 1'b0, 8'h60, 1'b0, 24'h0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("stall_out_valid_timeout");
    else begin
      for (int i = 0; i < 5; i++) begin
        check("stall_child", child_gene, exp_q[0].child);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        @(negedge clk);
      end
    end
    stall_hold = 1'b0;
    drain();

    // Saturation of mut_count.
    for (int i = 0; i < 90; i++) begin
      ga = {1'b0, 24'($urandom)};
      gb = {1'b0, 24'($urandom)};
      send(ga, gb, 1'b0, 1'($urandom), 8'hFF, 1'b0, 24'h0);
    end
    send(25'h0FFFFFF, 25'h0000000, 1'b1, 1'b0, 8'hFF, 1'b0, 24'h0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      ga = 25'($urandom);
      gb = 25'($urandom);
      if ($urandom_range(0, 7) != 0) gb[24] = ga[24];
      send(ga, gb, ($urandom_range(0, 5) == 0), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0), 24'($urandom));
    end
    drain();

    // Reset during ATTR abandons the gene and reloads seeds.
    send(25'h0111111, 25'h0222222, 1'b1, 1'b0, 8'hFF, 1'b0, 24'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_mut_count", mut_count, 0);
    exp_q.delete();
    model_reset();
    rst = 1'b0;
    send(25'h0A1B2C3, 25'h0D4E5F6, 1'b0, 1'b1, 8'hA0, 1'b0, 24'h0);
    send(25'h1A1B2C3, 25'h1D4E5F6, 1'b1, 1'b0, 8'h90, 1'b0, 24'h0);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gene_evolve_seq.md
Name: gene_evolve_seq

Overview:
- Sequences per-gene crossover and mutation for child genome generation.
- Accepts one parent-gene pair per transaction and draws random bytes from three internal LFSRs.
- Per attribute, applies the fixed-point crossover comparator (threshold 0x40), the mutation comparator and type-dependent value masking.
- Emits one child gene with a valid/ready handshake. Sits between the parent gene fetch and the child genome write-back.

Parameters:
- SEED0, 8'hA5, reset seed of the crossover LFSR (nonzero)
- SEED1, 8'h3C, reset seed of the mutation-decision LFSR (nonzero)
- SEED2, 8'h5F, reset seed of the mutated-value LFSR (nonzero)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  parent pair valid
- in_ready  out  1  controller can accept a pair
- gene_a  in  25  parent A gene: [24] type (0 node, 1 conn), [23:16] attr1, [15:8] attr2, [7:0] attr3
- gene_b  in  25  parent B gene, same format
- in_last  in  1  final gene of the genome
- bias  in  1  fitter parent: 0 = A, 1 = B
- mutation_prob  in  8  fixed-point threshold; MSB = 2^0, LSB = 2^-7
- rnd_force_en  in  1  test override of the LFSR outputs
- rnd_force  in  24  forced bytes {r2, r1, r0}
- out_valid  out  1  child gene valid
- out_ready  in  1  consumer accepts
- child_gene  out  25  resulting gene
- out_last  out  1  copy of in_last
- type_err  out  1  the two parents have different gene types
- mut_count  out  8  mutations applied in the current genome; saturates at 255
- done  out  1  one-cycle pulse after the last gene is accepted downstream

Behaviour:
- Reset: all outputs 0 except in_ready = 1; state IDLE; LFSRs loaded with their SEEDs; attribute index 0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shift left; the new LSB is the XOR of bits 7, 5, 4, 3.
  - All three LFSRs advance only in ATTR cycles, not while stalled.
  - When rnd_force_en = 1, the comparators use rnd_force bytes in place of the LFSR outputs; the LFSRs still advance.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: register both genes, in_last and bias; go to ATTR with k = 0. mutation_prob is sampled live in each ATTR cycle.
- ATTR (3 cycles, k = 0, 1, 2 → attr1, attr2, attr3):
  - Crossover select: sel = (r0 > 0x40) ? ~bias : bias. sel = 0 takes parent A's attribute, sel = 1 takes parent B's.
  - Mutation: mutate = !(r1 > mutation_prob).
    - mutation_prob = 0x00 never mutates, because the LFSR is never 0.
    - mutation_prob = 0xFF always mutates.
  - Mutated value, node type: attr1 = r2, attr2 = r2 & 0x0F, attr3 = r2 & 0x07.
  - Mutated value, conn type: attr1 = r2 & 0x01, attr2 = 0x00, attr3 = 0x00.
  - Each mutation increments mut_count (saturating).
  - After k = 2, go to EMIT.
- Type mismatch: if gene_a[24] != gene_b[24], skip ATTR.
  - EMIT gene_a unchanged with type_err = 1.
  - LFSRs do not advance; no mutation is counted.
- EMIT:
  - out_valid = 1; child_gene[24] = parent A type.
  - Hold child_gene, out_last and type_err stable until out_ready.
  - On the handshake, go to IDLE. If out_last was set, pulse done in the following cycle and clear mut_count in that same cycle.
- Latency: acceptance at cycle T gives out_valid at T+4 (T+1 on type mismatch). Peak throughput is 1 gene per 5 cycles.
- in_ready is 0 in every state except IDLE.
- rst asserted mid-operation abandons the gene, drops out_valid and reloads the seeds.

Decomposition:
- Package neat_evo_pkg:
  - gene field positions: GENE_W = 25, TYPE_BIT = 24
  - GENE_NODE = 0, GENE_CONN = 1
  - HALF = 8'h40
  - per-type attribute masks
  - state enum {IDLE, ATTR, EMIT}
- Sub-module lfsr8 (parameter SEED; ports clk, rst, en, q), instantiated three times.

Test Plan:
- Mutation off, crossover forced:
  - Stimulus: rnd_force_en = 1, rnd_force = {8'h00, 8'hFF, 8'h41}, bias = 0, mutation_prob = 0x00, node genes A = 0_11_22_33, B = 0_AA_BB_CC.
  - Response: child = 0_AA_BB_CC at T+4; mut_count = 0.
- Crossover threshold boundary: same stimulus as above with r0 = 8'h40. → child = 0_11_22_33; with bias = 1 → 0_AA_BB_CC.
- Forced mutation, node: rnd_force = {8'hDE, 8'h10, 8'h00}, mutation_prob = 0x20, node genes. → child = 0_DE_0E_06; mut_count = 3.
- Forced mutation, conn: same stimulus with conn genes. → child = 1_00_00_00.
- Type mismatch: A = 0_xx, B = 1_xx. → out_valid at T+1 with child = A and type_err = 1; LFSR state unchanged.
- Stall and last: out_ready held 0 for 5 cycles with in_last = 1.
  - Response: child_gene stable and in_ready = 0 throughout.
  - After the handshake: done pulses one cycle and mut_count returns to 0.
  - rst during ATTR → out_valid = 0, in_ready = 1 the next cycle.
